// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment loop-back checker: segment patterns,
// character codes, FSM states and the golden message sequence.
package seg_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned CODE_W = 5;

  typedef logic [CODE_W-1:0] code_t;

  // Segment patterns: bit7 = dp, bits6..0 = a..g, active-high
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
  localparam logic [SEG_W-1:0] SEG_MARK  = 8'h80;
  localparam logic [SEG_W-1:0] SEG_S     = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_E     = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_N     = 8'h15;
  localparam logic [SEG_W-1:0] SEG_O     = 8'h7E;
  localparam logic [SEG_W-1:0] SEG_L     = 8'h0E;
  localparam logic [SEG_W-1:0] SEG_G     = 8'h5F;
  localparam logic [SEG_W-1:0] SEG_U     = 8'h3E;

  localparam code_t C_BLANK = 5'd0;
  localparam code_t C_MARK  = 5'd1;
  localparam code_t C_S     = 5'd2;
  localparam code_t C_E     = 5'd3;
  localparam code_t C_N     = 5'd4;
  localparam code_t C_O     = 5'd5;
  localparam code_t C_L     = 5'd6;
  localparam code_t C_G     = 5'd7;
  localparam code_t C_U     = 5'd8;
  localparam code_t C_UNK   = 5'h1F;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_ARMED,
    ST_FRAME
  } state_e;

  localparam int unsigned GOLDEN_LEN = 13;

  // "SEnOLGULGOnUL"
  localparam code_t GOLDEN_SEQ [GOLDEN_LEN] = '{
    C_S, C_E, C_N, C_O, C_L, C_G, C_U, C_L, C_G, C_O, C_N, C_U, C_L
  };

endpackage

// File: rtl/seg_char_lut.sv
// Combinational segment-pattern to character-code lookup; exact match only,
// anything unrecognised decodes to C_UNK.
module seg_char_lut
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output code_t            code_o
);

  always_comb begin
    code_o = C_UNK;
    case (seg_i)
      SEG_BLANK: code_o = C_BLANK;
      SEG_MARK:  code_o = C_MARK;
      SEG_S:     code_o = C_S;
      SEG_E:     code_o = C_E;
      SEG_N:     code_o = C_N;
      SEG_O:     code_o = C_O;
      SEG_L:     code_o = C_L;
      SEG_G:     code_o = C_G;
      SEG_U:     code_o = C_U;
      default:   code_o = C_UNK;
    endcase
  end

endmodule

// File: rtl/seg_stream_decoder.sv
// Receive-side checker for the 7-segment message scroller: decodes samples,
// locks on blank+marker framing and scores each frame against the golden text.
// Define SEG_ACTIVE_LOW_EN to invert seg_in for common-anode displays.
module seg_stream_decoder
  import seg_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 13,
  parameter int unsigned ERR_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       seg_in,
  input  logic             seg_valid,
  output logic [4:0]       char_code,
  output logic             char_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [SEG_W-1:0] seg_eff;
  code_t            code;
  logic             char_bad;
  logic             err_sat;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mism_q, mism_d;
  code_t            code_q, code_d;
  logic             cv_q, cv_d;
  logic             fs_q, fs_d;
  logic             fd_q, fd_d;
  logic             ok_q, ok_d;
  logic [ERR_W-1:0] err_q, err_d;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_eff = ~seg_in;
`else
  assign seg_eff = seg_in;
`endif

  seg_char_lut u_lut (
    .seg_i  (seg_eff),
    .code_o (code)
  );

  assign char_bad = (code != GOLDEN_SEQ[idx_q]);
  assign err_sat  = &err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      idx_q   <= '0;
      mism_q  <= 1'b0;
      code_q  <= '0;
      cv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mism_q  <= mism_d;
      code_q  <= code_d;
      cv_q    <= cv_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Framing FSM; held-off samples leave all state untouched, pulses drop
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mism_d  = mism_q;
    code_d  = code_q;
    cv_d    = 1'b0;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;

    if (seg_valid) begin
      code_d = code;
      case (state_q)
        ST_HUNT: begin
          if (code == C_BLANK) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (code == C_MARK) begin
            state_d = ST_FRAME;
            idx_d   = '0;
            mism_d  = 1'b0;
            fs_d    = 1'b1;
          end else if (code != C_BLANK) begin
            state_d = ST_HUNT;
          end
        end
        ST_FRAME: begin
          if (code == C_MARK) begin
            // Marker mid-frame: abandon this frame and re-sync immediately
            idx_d  = '0;
            mism_d = 1'b0;
            fs_d   = 1'b1;
            if (!err_sat) err_d = err_q + ERR_W'(1);
          end else begin
            cv_d = 1'b1;
            if (char_bad) begin
              mism_d = 1'b1;
              if (!err_sat) err_d = err_q + ERR_W'(1);
            end
            if (idx_q == LAST_IDX) begin
              fd_d    = 1'b1;
              ok_d    = !(mism_q || char_bad);
              state_d = ST_HUNT;
              idx_d   = '0;
              mism_d  = 1'b0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  assign char_code   = code_q;
  assign char_valid  = cv_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_ok    = ok_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_seg_stream_decoder.sv
// Randomised self-checking bench for seg_stream_decoder against a behavioural
// frame model; honours SEG_ACTIVE_LOW_EN by inverting the driven patterns.
module tb_seg_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic       seg_valid = 1'b0;
  logic [4:0] char_code;
  logic       char_valid, frame_start, frame_done, frame_ok;
  logic [3:0] err_cnt;

  seg_stream_decoder #(.FRAME_LEN(13), .ERR_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .char_code   (char_code),
    .char_valid  (char_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Pattern table indexed by character code, and expected golden codes
  localparam logic [7:0] PATS [9] = '{8'h00, 8'h80, 8'h5B, 8'h4F, 8'h15,
                                      8'h7E, 8'h0E, 8'h5F, 8'h3E};
  localparam int GOLD [13] = '{2, 3, 4, 5, 6, 7, 8, 6, 7, 5, 4, 8, 6};
  localparam logic [7:0] CLEAN [15] = '{8'h00, 8'h80, 8'h5B, 8'h4F, 8'h15,
                                        8'h7E, 8'h0E, 8'h5F, 8'h3E, 8'h0E,
                                        8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: pos = -2 hunting, -1 seen blank, 0..12 next character slot
  int m_pos, m_err, m_code;
  bit m_bad, m_cv, m_fs, m_fd, m_ok;

  bit cap = 1'b0;
  int capq[$];
  int fd_cnt, fs_cnt;

  function automatic logic [7:0] phys(input logic [7:0] x);
`ifdef SEG_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  function automatic int m_decode(input logic [7:0] p);
    for (int i = 0; i < 9; i++) if (p == PATS[i]) return i;
    return 31;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pos = -2; m_err = 0; m_code = 0; m_bad = 0;
    m_cv = 0; m_fs = 0; m_fd = 0; m_ok = 0;
  endtask

  task automatic m_bump();
    if (m_err < 15) m_err++;
  endtask

  task automatic m_accept(input logic [7:0] s);
    int c;
    c = m_decode(s);
    m_code = c;
    if (m_pos == -2) begin
      if (c == 0) m_pos = -1;
    end else if (m_pos == -1) begin
      if (c == 1) begin m_pos = 0; m_bad = 0; m_fs = 1; end
      else if (c != 0) m_pos = -2;
    end else if (c == 1) begin
      m_bump(); m_fs = 1; m_pos = 0; m_bad = 0;
    end else begin
      m_cv = 1;
      if (c != GOLD[m_pos]) begin m_bad = 1; m_bump(); end
      if (m_pos == 12) begin m_fd = 1; m_ok = !m_bad; m_pos = -2; end
      else m_pos++;
    end
  endtask

  // One clock: drive, let the model consume the accepted sample, compare
  task automatic step(input bit v, input logic [7:0] s);
    @(negedge clk);
    seg_valid = v;
    seg_in = v ? phys(s) : 8'($urandom);
    @(posedge clk);
    m_cv = 0; m_fs = 0; m_fd = 0;
    if (v) m_accept(s);
    #1;
    cyc++;
    chk("char_code", int'(char_code), m_code);
    chk("char_valid", int'(char_valid), int'(m_cv));
    chk("frame_start", int'(frame_start), int'(m_fs));
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("frame_ok", int'(frame_ok), int'(m_ok));
    chk("err_cnt", int'(err_cnt), m_err);
    if (cap && char_valid) capq.push_back(int'(char_code));
    if (frame_done) fd_cnt++;
    if (frame_start) fs_cnt++;
  endtask

  task automatic send(input logic [7:0] s, input bit toggle);
    if (toggle) step(1'b0, 8'h00);
    step(1'b1, s);
  endtask

  task automatic clean_frame(input bit toggle);
    for (int i = 0; i < 15; i++) send(CLEAN[i], toggle);
  endtask

  initial begin
    logic [7:0] seq [15];
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_char_code", int'(char_code), 0);
    chk("rst_char_valid", int'(char_valid), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_ok", int'(frame_ok), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    rst_n = 1'b1;

    // Clean frame
    cap = 1; capq.delete(); fd_cnt = 0; fs_cnt = 0;
    clean_frame(1'b0);
    cap = 0;
    chk("t1_nchars", capq.size(), 13);
    for (int i = 0; i < 13 && i < capq.size(); i++) chk("t1_code", capq[i], GOLD[i]);
    chk("t1_fd_cnt", fd_cnt, 1);
    chk("t1_fs_cnt", fs_cnt, 1);
    chk("t1_ok", int'(frame_ok), 1);
    chk("t1_err", int'(err_cnt), 0);

    // 5th character corrupted, then a clean frame
    seq = CLEAN;
    seq[6] = 8'h7F;
    cap = 1; capq.delete();
    for (int i = 0; i < 15; i++) send(seq[i], 1'b0);
    cap = 0;
    chk("t2_code_unk", (capq.size() > 4) ? capq[4] : -1, 31);
    chk("t2_ok", int'(frame_ok), 0);
    chk("t2_err", int'(err_cnt), 1);
    clean_frame(1'b0);
    chk("t2_ok_after", int'(frame_ok), 1);
    chk("t2_err_after", int'(err_cnt), 1);

    // Marker after 4 characters re-syncs without a blank
    fd_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 6; i++) send(CLEAN[i], 1'b0);
    send(8'h80, 1'b0);
    chk("t3_no_done", fd_cnt, 0);
    chk("t3_err", int'(err_cnt), 2);
    for (int i = 2; i < 15; i++) send(CLEAN[i], 1'b0);
    chk("t3_fs_cnt", fs_cnt, 2);
    chk("t3_fd_cnt", fd_cnt, 1);
    chk("t3_ok", int'(frame_ok), 1);

    // Held-off cycles interleaved
    clean_frame(1'b1);
    chk("t4_ok", int'(frame_ok), 1);
    chk("t4_err", int'(err_cnt), 2);

    // Randomised frames with corruption, junk, stray markers and stalls
    for (int f = 0; f < 40; f++) begin
      int junk;
      junk = int'($urandom_range(0, 3));
      for (int j = 0; j < junk; j++)
        send(($urandom % 2 == 0) ? PATS[$urandom_range(0, 8)] : 8'($urandom), ($urandom % 3) == 0);
      send(8'h00, 1'b0);
      send(8'h80, ($urandom % 3) == 0);
      for (int i = 0; i < 13; i++) begin
        logic [7:0] p;
        p = PATS[GOLD[i]];
        if ($urandom % 10 == 0) p = PATS[$urandom_range(0, 8)];
        else if ($urandom % 25 == 0) p = 8'($urandom);
        send(p, ($urandom % 3) == 0);
      end
    end

    // Saturation with all-unknown frames
    for (int f = 0; f < 20; f++) begin
      send(8'h00, 1'b0);
      send(8'h80, 1'b0);
      for (int i = 0; i < 13; i++) send(8'h7F, 1'b0);
    end
    chk("t5_err_sat", int'(err_cnt), 15);
    chk("t5_ok", int'(frame_ok), 0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) send(CLEAN[i], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_char_code", int'(char_code), 0);
    chk("t6_rst_char_valid", int'(char_valid), 0);
    chk("t6_rst_frame_start", int'(frame_start), 0);
    chk("t6_rst_frame_done", int'(frame_done), 0);
    chk("t6_rst_frame_ok", int'(frame_ok), 0);
    chk("t6_rst_err_cnt", int'(err_cnt), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h80, 1'b0);
    chk("t6_hunt_no_start", int'(frame_start), 0);
    clean_frame(1'b0);
    chk("t6_ok", int'(frame_ok), 1);
    chk("t6_err", int'(err_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
